// File: rtl/mul_div_unit_pkg.sv
// Shared types for the EX-stage multiply/divide engine and HI/LO traffic.
// Op encodings and the 66-bit bus layout are shared with the HI/LO file.
package mul_div_unit_pkg;
    localparam int MD_OP_W    = 3;
    localparam int EX_TO_HILO = 66;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_e;

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_bus_t;

    function automatic logic [31:0] mag32(
        input logic [31:0] v,
        input logic        neg
    );
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/mul_div_unit_if.sv
// EX-side port bundle of the multiply/divide engine.
// master drives the operands, slave returns HI/LO writes and stall.
interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic        op_valid;
    md_op_e      md_op;
    logic [31:0] src1;
    logic [31:0] src2;
    hilo_bus_t   ex_to_hilo_bus;
    logic        stallreq;

    modport master (
        output op_valid, md_op, src1, src2,
        input  ex_to_hilo_bus, stallreq
    );

    modport slave (
        input  op_valid, md_op, src1, src2,
        output ex_to_hilo_bus, stallreq
    );
endinterface

// File: rtl/md_div_core.sv
// Restoring divider datapath, one quotient bit per step.
// Operates on magnitudes; sign fix-up belongs to the caller.
module md_div_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot,
    output logic [31:0] rem
);
    logic [31:0] q_r;
    logic [31:0] r_r;
    logic [31:0] d_r;
    logic [32:0] shifted;
    logic [32:0] diff;

    // q_r doubles as the dividend shift register
    assign shifted = {r_r, q_r[31]};
    assign diff    = shifted - {1'b0, d_r};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= '0;
            r_r <= '0;
            d_r <= '0;
        end else if (start) begin
            q_r <= dividend;
            r_r <= '0;
            d_r <= divisor;
        end else if (step) begin
            q_r <= {q_r[30:0], ~diff[32]};
            r_r <= diff[32] ? shifted[31:0] : diff[31:0];
        end
    end

    assign quot = q_r;
    assign rem  = r_r;
endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU engine plus MTHI/MTLO pass.
// Drives HI/LO write traffic and holds IF..EX while busy.
module mul_div_unit #(
    parameter int MUL_ITER = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           ex_stall,
    mul_div_unit_if.slave  md
);
    import mul_div_unit_pkg::*;

    md_state_e   state;
    md_state_e   state_nxt;
    logic [5:0]  cnt;
    logic [5:0]  cnt_nxt;
    logic        stall;
    hilo_bus_t   bus;
    logic        start;
    logic        mul_step;
    logic        div_step;

    logic        op_mul;
    logic        op_div;
    logic        op_mthi;
    logic        op_mtlo;
    logic        op_sgn;
    logic        neg_a_in;
    logic        neg_b_in;
    logic [31:0] a_in;
    logic [31:0] b_in;

    logic [31:0] a_q;
    logic        neg_a;
    logic        neg_b;
    logic        is_div;
    logic        dz;
    logic [31:0] src1_raw;
    logic [63:0] prod;
    logic [32:0] mul_sum;

    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] p_fix;
    hilo_bus_t   res_bus;

    assign op_mul  = md.md_op == MD_MULT || md.md_op == MD_MULTU;
    assign op_div  = md.md_op == MD_DIV  || md.md_op == MD_DIVU;
    assign op_mthi = md.md_op == MD_MTHI;
    assign op_mtlo = md.md_op == MD_MTLO;
    assign op_sgn  = md.md_op == MD_MULT || md.md_op == MD_DIV;

    assign neg_a_in = op_sgn & md.src1[31];
    assign neg_b_in = op_sgn & md.src2[31];
    assign a_in     = mag32(md.src1, neg_a_in);
    assign b_in     = mag32(md.src2, neg_b_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        bus       = '0;
        start     = 1'b0;
        mul_step  = 1'b0;
        div_step  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (md.op_valid) begin
                    unique case (1'b1)
                        op_mul: begin
                            stall     = 1'b1;
                            start     = 1'b1;
                            state_nxt = ST_MUL;
                            cnt_nxt   = '0;
                        end
                        op_div: begin
                            stall     = 1'b1;
                            start     = 1'b1;
                            state_nxt = ST_DIV;
                            cnt_nxt   = '0;
                        end
                        op_mthi: begin
                            bus.hi_we = 1'b1;
                            bus.hi    = md.src1;
                        end
                        op_mtlo: begin
                            bus.lo_we = 1'b1;
                            bus.lo    = md.src1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                stall    = 1'b1;
                mul_step = 1'b1;
                if (cnt == 6'd31 || MUL_ITER == 0) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 6'd1;
                end
            end
            ST_DIV: begin
                stall    = 1'b1;
                div_step = 1'b1;
                if (cnt == 6'd31) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 6'd1;
                end
            end
            ST_DONE: begin
                bus = res_bus;
                if (!ex_stall) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // flush kills the op and any write in the same cycle
        if (flush) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            stall     = 1'b0;
            bus       = '0;
            start     = 1'b0;
            mul_step  = 1'b0;
            div_step  = 1'b0;
        end
    end

    assign mul_sum = {1'b0, prod[63:32]}
                   + (prod[0] ? {1'b0, a_q} : 33'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            is_div   <= 1'b0;
            dz       <= 1'b0;
            src1_raw <= '0;
            prod     <= '0;
        end else if (start) begin
            a_q      <= a_in;
            neg_a    <= neg_a_in;
            neg_b    <= neg_b_in;
            is_div   <= op_div;
            dz       <= op_div && md.src2 == 32'd0;
            src1_raw <= md.src1;
            prod     <= {32'd0, b_in};
        end else if (mul_step) begin
            // low half holds the multiplier and shifts out as product bits land
            if (MUL_ITER == 0)
                prod <= {32'd0, a_q} * {32'd0, prod[31:0]};
            else
                prod <= {mul_sum, prod[31:1]};
        end
    end

    md_div_core u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start && op_div),
        .step     (div_step),
        .dividend (a_in),
        .divisor  (b_in),
        .quot     (quot),
        .rem      (rem)
    );

    assign p_fix = (neg_a ^ neg_b) ? -prod : prod;

    always_comb begin
        res_bus.hi_we = 1'b1;
        res_bus.lo_we = 1'b1;
        res_bus.hi    = p_fix[63:32];
        res_bus.lo    = p_fix[31:0];
        if (is_div) begin
            if (dz) begin
                res_bus.hi = src1_raw;
                res_bus.lo = 32'hFFFF_FFFF;
            end else begin
                res_bus.hi = mag32(rem, neg_a);
                res_bus.lo = mag32(quot, neg_a ^ neg_b);
            end
        end
    end

    assign md.ex_to_hilo_bus = bus;
    assign md.stallreq       = stall;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a transaction-level model.
// Model results come from plain integer arithmetic.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    logic ex_stall;

    mul_div_unit_if md_if ();

    mul_div_unit #(.MUL_ITER(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .ex_stall (ex_stall),
        .md       (md_if)
    );

    logic [65:0] bus;
    assign bus = md_if.ex_to_hilo_bus;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_live = 0;
    int          m_busy = 0;
    bit          m_done = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    function automatic bit is_arith(input md_op_e op);
        return op == MD_MULT || op == MD_MULTU ||
               op == MD_DIV  || op == MD_DIVU;
    endfunction

    task automatic ref_calc(
        input  md_op_e      op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] hi,
        output logic [31:0] lo
    );
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            MD_MULT: begin
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            MD_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == MD_DIVU) begin
                    hi = a % b;
                    lo = a / b;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p  = 64'(sq);
                    lo = p[31:0];
                    p  = 64'(sr);
                    hi = p[31:0];
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live = 1;
            m_busy = 0;
            m_done = 0;
        end else if (m_live) begin
            if (flush) begin
                m_busy = 0;
                m_done = 0;
            end else if (m_done) begin
                m_done = ex_stall;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_done = 1;
            end else if (md_if.op_valid && is_arith(md_if.md_op)) begin
                ref_calc(md_if.md_op, md_if.src1, md_if.src2, m_hi, m_lo);
                m_busy = 32;
            end
        end
    end

    always @(negedge clk) begin
        logic        exp_stall;
        logic [65:0] exp_bus;
        if (m_live) begin
            exp_stall = 1'b0;
            exp_bus   = '0;
            if (flush) begin
                exp_bus = '0;
            end else if (m_done) begin
                exp_bus = {2'b11, m_hi, m_lo};
            end else if (m_busy > 0) begin
                exp_stall = 1'b1;
            end else if (md_if.op_valid) begin
                if (is_arith(md_if.md_op))
                    exp_stall = 1'b1;
                else if (md_if.md_op == MD_MTHI)
                    exp_bus = {2'b10, md_if.src1, 32'd0};
                else if (md_if.md_op == MD_MTLO)
                    exp_bus = {2'b01, 32'd0, md_if.src1};
            end
            n_cmp++;
            if (bus !== exp_bus || md_if.stallreq !== exp_stall) begin
                n_bad++;
                $display("FAIL model t=%0t: got stall=%b bus=%h want stall=%b bus=%h",
                         $time, md_if.stallreq, bus, exp_stall, exp_bus);
            end
        end
    end

    task automatic check(
        input string       name,
        input logic [65:0] got,
        input logic [65:0] want
    );
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic run_op(
        input string       name,
        input md_op_e      op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] want_hi,
        input logic [31:0] want_lo,
        input int          hold
    );
        int          stalls;
        bit          got;
        logic [65:0] cap;
        stalls = 0;
        got    = 0;
        cap    = '0;
        @(posedge clk);
        #1;
        md_if.op_valid = 1'b1;
        md_if.md_op    = op;
        md_if.src1     = a;
        md_if.src2     = b;
        ex_stall       = (hold > 0);
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (md_if.stallreq) stalls++;
            else if (bus[65:64] == 2'b11) begin
                got = 1;
                cap = bus;
            end
        end
        check({name, " stalls"}, 66'(stalls), 66'd33);
        check({name, " result"}, cap, {2'b11, want_hi, want_lo});
        for (int k = 1; k <= hold && got; k++) begin
            @(posedge clk);
            #1;
            if (k == hold) ex_stall = 1'b0;
            @(negedge clk);
            check({name, " held bus"}, bus, cap);
            check({name, " held stall"}, 66'(md_if.stallreq), 66'd0);
        end
        @(posedge clk);
        #1;
        md_if.op_valid = 1'b0;
        md_if.md_op    = MD_NONE;
        ex_stall       = 1'b0;
        @(negedge clk);
        check({name, " idle"}, {bus[65:64], 63'd0, md_if.stallreq}, '0);
    endtask

    initial begin
        int bad;
        rst_n          = 1'b0;
        flush          = 1'b0;
        ex_stall       = 1'b0;
        md_if.op_valid = 1'b0;
        md_if.md_op    = MD_NONE;
        md_if.src1     = '0;
        md_if.src2     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset bus", bus, '0);
        check("reset stall", 66'(md_if.stallreq), 66'd0);

        run_op("mult -3*5", MD_MULT, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        run_op("divu 100/7", MD_DIVU, 32'd100, 32'd7,
               32'h0000_0002, 32'h0000_000E, 0);
        run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD, 0);
        run_op("divu 1234/0", MD_DIVU, 32'd1234, 32'd0,
               32'h0000_04D2, 32'hFFFF_FFFF, 0);
        run_op("div -7/0", MD_DIV, 32'hFFFF_FFF9, 32'd0,
               32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
        run_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 0);
        run_op("multu 2^16*2^16", MD_MULTU, 32'h0001_0000, 32'h0001_0000,
               32'h0000_0001, 32'h0000_0000, 0);
        run_op("multu max*max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("div 100/-3 held", MD_DIV, 32'd100, 32'hFFFF_FFFD,
               32'h0000_0001, 32'hFFFF_FFDF, 3);

        // flush in the 10th stall cycle
        @(posedge clk);
        #1;
        md_if.op_valid = 1'b1;
        md_if.md_op    = MD_MULTU;
        md_if.src1     = 32'hFFFF_FFFF;
        md_if.src2     = 32'hFFFF_FFFF;
        repeat (9) @(posedge clk);
        #1;
        flush          = 1'b1;
        md_if.op_valid = 1'b0;
        md_if.md_op    = MD_NONE;
        @(negedge clk);
        check("flush stall", 66'(md_if.stallreq), 66'd0);
        check("flush bus", bus, '0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        bad   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus[65] || bus[64] || md_if.stallreq) bad = 1;
        end
        check("flush quiet", 66'(bad), 66'd0);

        // MTHI then MTLO back to back
        @(posedge clk);
        #1;
        md_if.op_valid = 1'b1;
        md_if.md_op    = MD_MTHI;
        md_if.src1     = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi bus", bus, {2'b10, 32'hDEAD_BEEF, 32'd0});
        check("mthi stall", 66'(md_if.stallreq), 66'd0);
        @(posedge clk);
        #1;
        md_if.md_op = MD_MTLO;
        md_if.src1  = 32'h1234_5678;
        @(negedge clk);
        check("mtlo bus", bus, {2'b01, 32'd0, 32'h1234_5678});
        check("mtlo stall", 66'(md_if.stallreq), 66'd0);

        // reset in the middle of a MULT
        @(posedge clk);
        #1;
        md_if.md_op = MD_MULT;
        md_if.src1  = 32'd7;
        md_if.src2  = 32'd9;
        repeat (5) @(posedge clk);
        #1;
        rst_n          = 1'b0;
        md_if.op_valid = 1'b0;
        md_if.md_op    = MD_NONE;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid reset bus", bus, '0);
        check("mid reset stall", 66'(md_if.stallreq), 66'd0);

        run_op("mult after reset", MD_MULT, 32'd7, 32'hFFFF_FFF7,
               32'hFFFF_FFFF, 32'hFFFF_FFC1, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000");
        $fatal(1, "timeout");
    end
endmodule
